// File: rtl/nes_joypad_device.sv
// -----------------------------------------------------------------------------
// nes_joypad_device
//
// Device (controller) side of the NES serial joypad protocol. Emulates a pair
// of CD4021-style pads: the host raises joy_latch to parallel-load the button
// state, then each rising joy_pulse shifts the next button out on joy_data0/1
// (A, B, Select, Start, Up, Down, Left, Right), followed by constant 1s.
//
// Button state arrives from an upstream source over a valid/ready handshake
// and is held in a 16-bit shadow register. joy_latch and joy_pulse are
// asynchronous pins: they are synchronized, glitch-filtered and edge-detected
// in the sysclk domain. Pin edge to joy_data change is SYNC_STAGES + FILTER_LEN
// sysclk cycles.
//
// Optional feature (macro NES_JOYPAD_TURBO_EN): adds turbo_mask[15:0] and
// parameter TURBO_DIV. Masked buttons read as released on alternating groups
// of TURBO_DIV frames (a frame ends with read_done).
//
// Ports:
//   sysclk      in   system clock
//   reset       in   asynchronous, active-low reset
//   btn_valid   in   upstream button word valid
//   btn_ready   out  block accepts btn_data this cycle (low only while loading)
//   btn_data    in   {pad1[7:0], pad0[7:0]}, bit0 A .. bit7 Right, 1 = pressed
//   turbo_mask  in   (NES_JOYPAD_TURBO_EN only) buttons subject to turbo
//   joy_latch   in   host latch pin, asynchronous
//   joy_pulse   in   host clock pin, asynchronous
//   joy_data0   out  pad0 serial data
//   joy_data1   out  pad1 serial data
//   read_done   out  one-cycle pulse when the 8th shift of a sequence completes
// -----------------------------------------------------------------------------
module nes_joypad_device #(
    parameter int SYNC_STAGES     = 2,
    parameter int FILTER_LEN      = 2,
    parameter bit DATA_ACTIVE_LOW = 1'b0
`ifdef NES_JOYPAD_TURBO_EN
    ,
    parameter int TURBO_DIV       = 2
`endif
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        btn_valid,
    output logic        btn_ready,
    input  logic [15:0] btn_data,
`ifdef NES_JOYPAD_TURBO_EN
    input  logic [15:0] turbo_mask,
`endif
    input  logic        joy_latch,
    input  logic        joy_pulse,
    output logic        joy_data0,
    output logic        joy_data1,
    output logic        read_done
);

    // Lane 0 carries joy_latch, lane 1 carries joy_pulse.
    localparam int HIST_W = (FILTER_LEN > 1) ? FILTER_LEN - 1 : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        EXHAUST
    } state_e;

    logic [SYNC_STAGES-1:0][1:0] sync_q;
    logic [HIST_W-1:0][1:0]      hist_q, hist_d;
    logic [1:0]                  acc_q, acc_d;
    logic [1:0]                  samp;

    logic        lat_rise, lat_fall, pul_rise;
    state_e      state_q, state_d;
    logic [15:0] shadow_q;
    logic [15:0] load_word;
    logic [7:0]  shift0_q, shift1_q;
    logic [3:0]  count_q;
    logic        read_done_q, read_done_d;
    logic        load_en, shift_en;

    // ------------------------------------------------------------------
    // Pin synchronizers and glitch filter
    // ------------------------------------------------------------------
    assign samp = sync_q[SYNC_STAGES-1];

    // NOTE: every clocked process uses non-blocking assignments so all
    // registers update together from pre-edge values.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            hist_q <= '0;
            acc_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {joy_pulse, joy_latch}};
            hist_q <= hist_d;
            acc_q  <= acc_d;
        end
    end

    // The filter window is the current synchronized sample plus the previous
    // FILTER_LEN-1 samples; the accepted level moves only when all agree.
    always_comb begin
        logic all_hi;
        logic all_lo;
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned (which would infer a latch).
        hist_d = '0;
        acc_d  = acc_q;
        all_hi = 1'b0;
        all_lo = 1'b0;
        hist_d[0] = samp;
        for (int i = 1; i < HIST_W; i++) begin
            hist_d[i] = hist_q[i-1];
        end
        for (int l = 0; l < 2; l++) begin
            all_hi = samp[l];
            all_lo = ~samp[l];
            for (int i = 0; i < FILTER_LEN - 1; i++) begin
                all_hi = all_hi & hist_q[i][l];
                all_lo = all_lo & ~hist_q[i][l];
            end
            if (all_hi) begin
                acc_d[l] = 1'b1;
            end else if (all_lo) begin
                acc_d[l] = 1'b0;
            end
        end
    end

    // Events act on the same edge at which the new level is accepted.
    assign lat_rise = acc_d[0] & ~acc_q[0];
    assign lat_fall = ~acc_d[0] & acc_q[0];
    assign pul_rise = acc_d[1] & ~acc_q[1];

    // ------------------------------------------------------------------
    // Turbo phase (optional)
    // ------------------------------------------------------------------
`ifdef NES_JOYPAD_TURBO_EN
    localparam int FRAME_W = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

    logic [FRAME_W-1:0] frame_q;
    logic               phase_q;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            frame_q <= '0;
            phase_q <= 1'b1;
        end else if (read_done_d) begin
            if (frame_q == FRAME_W'(TURBO_DIV - 1)) begin
                frame_q <= '0;
                phase_q <= ~phase_q;
            end else begin
                frame_q <= frame_q + 1'b1;
            end
        end
    end

    // While phase is 0 the masked buttons read as released.
    assign load_word = shadow_q & ~(turbo_mask & {16{~phase_q}});
`else
    assign load_word = shadow_q;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. A latch rise wins over everything, from any state.
    always_comb begin
        state_d = state_q;
        if (lat_rise) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                LOAD:    if (lat_fall) state_d = SHIFT;
                SHIFT:   if (pul_rise && count_q == 4'd7) state_d = EXHAUST;
                default: state_d = state_q;
            endcase
        end
    end

    // FSM: outputs / datapath controls. Pulses are ignored while loading.
    always_comb begin
        load_en     = lat_rise || (state_q == LOAD);
        shift_en    = pul_rise && !load_en;
        read_done_d = shift_en && (state_q == SHIFT) && (count_q == 4'd7);
    end

    // ------------------------------------------------------------------
    // Shadow, shift registers, bit counter
    // ------------------------------------------------------------------
    // The shadow is frozen during LOAD so the loaded word is never torn.
    assign btn_ready = (state_q != LOAD);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            shadow_q    <= 16'h0000;
            shift0_q    <= 8'h00;
            shift1_q    <= 8'h00;
            count_q     <= 4'd0;
            read_done_q <= 1'b0;
        end else begin
            read_done_q <= read_done_d;
            if (btn_valid && btn_ready) begin
                shadow_q <= btn_data;
            end
            if (load_en) begin
                shift0_q <= load_word[7:0];
                shift1_q <= load_word[15:8];
                count_q  <= 4'd0;
            end else if (shift_en) begin
                // Ones fill from the top, so an exhausted pad reads 1.
                shift0_q <= {1'b1, shift0_q[7:1]};
                shift1_q <= {1'b1, shift1_q[7:1]};
                if (count_q != 4'd8) begin
                    count_q <= count_q + 4'd1;
                end
            end
        end
    end

    assign joy_data0 = shift0_q[0] ^ DATA_ACTIVE_LOW;
    assign joy_data1 = shift1_q[0] ^ DATA_ACTIVE_LOW;
    assign read_done = read_done_q;

endmodule

// File: tb/tb_nes_joypad_device.sv
// -----------------------------------------------------------------------------
// tb_nes_joypad_device
//
// Self-checking bench for nes_joypad_device. A behavioural pad model (accepted
// pin levels from a sample window, a loaded 16-bit word and a read index)
// predicts btn_ready, read_done and joy_data0/1 every cycle; directed host
// sequences add literal expectations, followed by randomized host traffic.
// Build with NES_JOYPAD_TURBO_EN defined to also exercise turbo.
// -----------------------------------------------------------------------------
module tb_nes_joypad_device;

    localparam int SYNC_STAGES     = 2;
    localparam int FILTER_LEN      = 2;
    localparam bit DATA_ACTIVE_LOW = 1'b0;
`ifdef NES_JOYPAD_TURBO_EN
    localparam int TURBO_DIV       = 2;
`endif

    logic        sysclk = 1'b0;
    logic        reset = 1'b0;
    logic        btn_valid = 1'b0;
    logic [15:0] btn_data = 16'h0000;
    logic        joy_latch = 1'b0;
    logic        joy_pulse = 1'b0;
    logic        btn_ready;
    logic        joy_data0;
    logic        joy_data1;
    logic        read_done;
`ifdef NES_JOYPAD_TURBO_EN
    logic [15:0] turbo_mask = 16'h0000;
`endif

    int errors = 0;
    int checks = 0;
    int rd_seen = 0;

    nes_joypad_device #(
        .SYNC_STAGES    (SYNC_STAGES),
        .FILTER_LEN     (FILTER_LEN),
        .DATA_ACTIVE_LOW(DATA_ACTIVE_LOW)
`ifdef NES_JOYPAD_TURBO_EN
        ,
        .TURBO_DIV      (TURBO_DIV)
`endif
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .btn_valid (btn_valid),
        .btn_ready (btn_ready),
        .btn_data  (btn_data),
`ifdef NES_JOYPAD_TURBO_EN
        .turbo_mask(turbo_mask),
`endif
        .joy_latch (joy_latch),
        .joy_pulse (joy_pulse),
        .joy_data0 (joy_data0),
        .joy_data1 (joy_data1),
        .read_done (read_done)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    bit          hl [256];
    bit          hp [256];
    int          edge_n;
    bit          m_acc_l, m_acc_p;
    bit          m_loading, m_armed, m_rd;
    logic [15:0] m_shadow, m_word;
    int          m_idx;
    int          m_frames;

    function automatic bit sampled(input int lane, input int k);
        if (k < 1) return 1'b0;
        return (lane == 0) ? hl[k % 256] : hp[k % 256];
    endfunction

    // A level is accepted once the pin was seen at that level on FILTER_LEN
    // consecutive sampling edges, SYNC_STAGES edges earlier.
    function automatic bit window_all(input int lane, input bit v);
        for (int j = 0; j < FILTER_LEN; j++) begin
            if (sampled(lane, edge_n - SYNC_STAGES - j) != v) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [15:0] load_value();
`ifdef NES_JOYPAD_TURBO_EN
        bit ph;
        ph = ((m_frames / TURBO_DIV) % 2) == 0;
        return m_shadow & ~(turbo_mask & {16{~ph}});
`else
        return m_shadow;
`endif
    endfunction

    task automatic model_reset();
        edge_n    = 0;
        m_acc_l   = 1'b0;
        m_acc_p   = 1'b0;
        m_loading = 1'b0;
        m_armed   = 1'b0;
        m_rd      = 1'b0;
        m_shadow  = 16'h0000;
        m_word    = 16'h0000;
        m_idx     = 0;
        m_frames  = 0;
    endtask

    task automatic model_step();
        bit lr, lf, pr, cap;
        edge_n++;
        hl[edge_n % 256] = joy_latch;
        hp[edge_n % 256] = joy_pulse;
        lr = 1'b0;
        lf = 1'b0;
        pr = 1'b0;
        if (!m_acc_l && window_all(0, 1'b1)) begin m_acc_l = 1'b1; lr = 1'b1; end
        else if (m_acc_l && window_all(0, 1'b0)) begin m_acc_l = 1'b0; lf = 1'b1; end
        if (!m_acc_p && window_all(1, 1'b1)) begin m_acc_p = 1'b1; pr = 1'b1; end
        else if (m_acc_p && window_all(1, 1'b0)) m_acc_p = 1'b0;
        cap  = btn_valid && !m_loading;
        m_rd = 1'b0;
        if (lr) begin
            m_loading = 1'b1;
            m_armed   = 1'b0;
        end else if (lf) begin
            m_loading = 1'b0;
            m_word    = load_value();
            m_idx     = 0;
            m_armed   = 1'b1;
        end else if (pr && !m_loading) begin
            if (m_idx < 8) m_idx++;
            if (m_idx == 8 && m_armed) begin
                m_rd    = 1'b1;
                m_armed = 1'b0;
                m_frames++;
            end
        end
        if (cap) m_shadow = btn_data;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge sysclk or negedge reset);
            if (!reset) model_reset();
            else model_step();
        end
    end

    // Compare process: DUT outputs against the model, away from the clock edge.
    initial begin
        forever begin
            @(negedge sysclk);
            if (reset) begin
                check("ready", 32'(btn_ready), 32'(!m_loading));
                check("read_done", 32'(read_done), 32'(m_rd));
                if (!m_loading) begin
                    check("data0", 32'(joy_data0),
                          32'(((m_idx < 8) ? m_word[m_idx] : 1'b1) ^ DATA_ACTIVE_LOW));
                    check("data1", 32'(joy_data1),
                          32'(((m_idx < 8) ? m_word[8 + m_idx] : 1'b1) ^ DATA_ACTIVE_LOW));
                end
                if (read_done) rd_seen++;
            end
        end
    end

    initial begin
        repeat (60000) @(posedge sysclk);
        $display("FAIL watchdog: cycle budget expired");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Host-side stimulus helpers (all aligned to the falling edge)
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic tick_rand(input int n);
        repeat (n) begin
            btn_valid = ($urandom_range(0, 5) == 0);
            btn_data  = 16'($urandom);
            @(negedge sysclk);
        end
    endtask

    task automatic write_btn(input logic [15:0] w);
        btn_data  = w;
        btn_valid = 1'b1;
        tick(1);
        btn_valid = 1'b0;
        tick(2);
    endtask

    task automatic latch_phase();
        joy_latch = 1'b1;
        tick(12);
        joy_latch = 1'b0;
        tick(6);
    endtask

    // Samples the bit before each pulse, plus one after the last pulse.
    task automatic shift_read(input int n, output logic [31:0] s0, output logic [31:0] s1);
        s0 = '0;
        s1 = '0;
        for (int i = 0; i < n; i++) begin
            s0[i] = joy_data0 ^ DATA_ACTIVE_LOW;
            s1[i] = joy_data1 ^ DATA_ACTIVE_LOW;
            joy_pulse = 1'b1;
            tick(6);
            joy_pulse = 1'b0;
            tick(6);
        end
        s0[n] = joy_data0 ^ DATA_ACTIVE_LOW;
        s1[n] = joy_data1 ^ DATA_ACTIVE_LOW;
    endtask

    task automatic host_read(input int n, output logic [31:0] s0, output logic [31:0] s1);
        latch_phase();
        shift_read(n, s0, s1);
    endtask

    // ------------------------------------------------------------------
    // Directed and random sequences
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] s0, s1;
        int          r0;
        int          lw, np;
        bit          both;

        #12;
        check("reset_ready", 32'(btn_ready), 32'd1);
        check("reset_read_done", 32'(read_done), 32'd0);
        check("reset_data0", 32'(joy_data0), 32'(DATA_ACTIVE_LOW));
        check("reset_data1", 32'(joy_data1), 32'(DATA_ACTIVE_LOW));
        @(negedge sysclk);
        reset = 1'b1;
        tick(4);

        // Empty shadow: eight zeros then ones.
        r0 = rd_seen;
        host_read(8, s0, s1);
        check("empty_pad0", s0, 32'h100);
        check("empty_pad1", s1, 32'h100);
        check("empty_rd", 32'(rd_seen - r0), 32'd1);

        // Known word, nine pulses.
        write_btn(16'hA581);
        r0 = rd_seen;
        host_read(9, s0, s1);
        check("a581_pad0", s0, 32'h381);
        check("a581_pad1", s1, 32'h3A5);
        check("a581_rd", 32'(rd_seen - r0), 32'd1);

        // Word offered during LOAD is held off until the latch fall is accepted.
        joy_latch = 1'b1;
        tick(6);
        check("load_ready_low", 32'(btn_ready), 32'd0);
        btn_data  = 16'h00FE;
        btn_valid = 1'b1;
        tick(6);
        joy_latch = 1'b0;
        tick(2);
        check("load_ready_still_low", 32'(btn_ready), 32'd0);
        tick(4);
        check("ready_after_fall", 32'(btn_ready), 32'd1);
        btn_valid = 1'b0;
        r0 = rd_seen;
        shift_read(8, s0, s1);
        check("held_old_pad0", s0, 32'h181);
        check("held_old_pad1", s1, 32'h1A5);
        host_read(8, s0, s1);
        check("held_new_pad0", s0, 32'h1FE);
        check("held_new_pad1", s1, 32'h100);
        check("held_rd", 32'(rd_seen - r0), 32'd2);

        // Abort after three pulses: reload, no read_done, then one full read.
        r0 = rd_seen;
        host_read(3, s0, s1);
        check("abort_bit3", 32'(joy_data0 ^ DATA_ACTIVE_LOW), 32'd1);
        latch_phase();
        check("abort_bitA", 32'(joy_data0 ^ DATA_ACTIVE_LOW), 32'd0);
        check("abort_no_rd", 32'(rd_seen - r0), 32'd0);
        shift_read(8, s0, s1);
        check("abort_full_pad0", s0, 32'h1FE);
        check("abort_full_rd", 32'(rd_seen - r0), 32'd1);

        // One-cycle pulse glitch is filtered; a two-cycle pulse shifts.
        latch_phase();
        joy_pulse = 1'b1;
        tick(1);
        joy_pulse = 1'b0;
        tick(8);
        check("glitch_no_shift", 32'(joy_data0 ^ DATA_ACTIVE_LOW), 32'd0);
        joy_pulse = 1'b1;
        tick(2);
        joy_pulse = 1'b0;
        tick(8);
        check("short_pulse_shift", 32'(joy_data0 ^ DATA_ACTIVE_LOW), 32'd1);

        // Latch and pulse rise together: load only.
        r0 = rd_seen;
        joy_latch = 1'b1;
        joy_pulse = 1'b1;
        tick(12);
        joy_pulse = 1'b0;
        tick(2);
        joy_latch = 1'b0;
        tick(6);
        check("same_cycle_bitA", 32'(joy_data0 ^ DATA_ACTIVE_LOW), 32'd0);
        shift_read(8, s0, s1);
        check("same_cycle_pad0", s0, 32'h1FE);
        check("same_cycle_rd", 32'(rd_seen - r0), 32'd1);

        // Asynchronous reset mid-sequence drops everything, including the shadow.
        write_btn(16'hFFFF);
        host_read(2, s0, s1);
        joy_pulse = 1'b1;
        tick(2);
        @(posedge sysclk);
        #2;
        reset = 1'b0;
        #1;
        check("areset_ready", 32'(btn_ready), 32'd1);
        check("areset_read_done", 32'(read_done), 32'd0);
        check("areset_data0", 32'(joy_data0), 32'(DATA_ACTIVE_LOW));
        check("areset_data1", 32'(joy_data1), 32'(DATA_ACTIVE_LOW));
        @(negedge sysclk);
        joy_pulse = 1'b0;
        joy_latch = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(2);
        host_read(8, s0, s1);
        check("after_reset_pad0", s0, 32'h100);
        check("after_reset_pad1", s1, 32'h100);

        // Randomized host traffic and button updates, checked by the model.
        for (int it = 0; it < 100; it++) begin
            lw   = $urandom_range(1, 14);
            both = ($urandom_range(0, 9) == 0);
            joy_latch = 1'b1;
            if (both) joy_pulse = 1'b1;
            tick_rand(lw);
            joy_latch = 1'b0;
            joy_pulse = 1'b0;
            tick_rand($urandom_range(1, 8));
            np = $urandom_range(0, 10);
            for (int p = 0; p < np; p++) begin
                joy_pulse = 1'b1;
                tick_rand($urandom_range(1, 6));
                joy_pulse = 1'b0;
                tick_rand($urandom_range(1, 6));
            end
        end
        btn_valid = 1'b0;
        tick(8);

`ifdef NES_JOYPAD_TURBO_EN
        // Turbo on A: two frames pressed, two released, two pressed.
        begin
            logic [5:0] seq;
            seq = '0;
            reset = 1'b0;
            tick(2);
            reset = 1'b1;
            tick(2);
            turbo_mask = 16'h0001;
            write_btn(16'h0001);
            for (int f = 0; f < 6; f++) begin
                host_read(8, s0, s1);
                seq[f] = s0[0];
            end
            check("turbo_seq", 32'(seq), 32'(6'b110011));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
